// File: rtl/wash_pkg.sv
// ============================================================================
// Module   : wash_pkg
// Purpose  : State encoding and shared helpers for the wash cycle controller
//            and the front-panel display decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wash_pkg;

  localparam int NUM_STATES = 10;
  localparam int c_STATE_W  = 4;

  localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 4'd0;
  localparam logic [c_STATE_W-1:0] c_ST_FILL1  = 4'd1;
  localparam logic [c_STATE_W-1:0] c_ST_WASH   = 4'd2;
  localparam logic [c_STATE_W-1:0] c_ST_DRAIN1 = 4'd3;
  localparam logic [c_STATE_W-1:0] c_ST_FILL2  = 4'd4;
  localparam logic [c_STATE_W-1:0] c_ST_RINSE  = 4'd5;
  localparam logic [c_STATE_W-1:0] c_ST_DRAIN2 = 4'd6;
  localparam logic [c_STATE_W-1:0] c_ST_SPIN   = 4'd7;
  localparam logic [c_STATE_W-1:0] c_ST_DONE   = 4'd8;
  localparam logic [c_STATE_W-1:0] c_ST_FAULT  = 4'd9;

  // Active programme states are the contiguous block FILL1..SPIN.
  function automatic logic is_active(input logic [c_STATE_W-1:0] s);
    return (s >= c_ST_FILL1) && (s <= c_ST_SPIN);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_timer.sv
// ============================================================================
// Module   : sec_timer
// Purpose  : Tick prescaler plus seconds counter used to time programme phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_timer #(
  parameter int TICKS_PER_SEC = 190,
  parameter int SECS_W        = 10
) (
  input  logic              clk190,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic              sec_tick,
  output logic [SECS_W-1:0] secs
);

  localparam int                 c_PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_TC = c_PRE_W'(TICKS_PER_SEC - 1);

  logic [c_PRE_W-1:0] r_pre;
  logic [SECS_W-1:0]  r_secs;

  // sec_tick is exported so the controller can end a phase on the same edge
  // that completes its final second.
  assign sec_tick = en && (r_pre == c_PRE_TC);
  assign secs     = r_secs;

  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_secs <= '0;
    end else if (clr) begin
      r_pre  <= '0;
      r_secs <= '0;
    end else if (en) begin
      if (sec_tick) begin
        r_pre <= '0;
        if (r_secs != '1) r_secs <= r_secs + SECS_W'(1);
      end else begin
        r_pre <= r_pre + c_PRE_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wash_cycle_ctrl.sv
// ============================================================================
// Module   : wash_cycle_ctrl
// Purpose  : Washing machine programme sequencer (fill/wash/drain/rinse/spin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = 190,
  parameter int WASH_SEC      = 600,
  parameter int RINSE_SEC     = 300,
  parameter int SPIN_SEC      = 240,
  parameter int TIMEOUT_SEC   = 120
) (
  input  logic       clk190,
  input  logic       rst,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       water_empty,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_en,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       paused,
  output logic       done,
  output logic       fault,
  output logic [3:0] state_o
);

  localparam int c_MAX_SEC = max4(WASH_SEC, RINSE_SEC, SPIN_SEC, TIMEOUT_SEC);
  localparam int c_SECS_W  = $clog2(c_MAX_SEC + 1);

  localparam logic [c_SECS_W-1:0] c_WASH_LAST  = c_SECS_W'(WASH_SEC - 1);
  localparam logic [c_SECS_W-1:0] c_RINSE_LAST = c_SECS_W'(RINSE_SEC - 1);
  localparam logic [c_SECS_W-1:0] c_SPIN_LAST  = c_SECS_W'(SPIN_SEC - 1);
  localparam logic [c_SECS_W-1:0] c_TOUT_LAST  = c_SECS_W'(TIMEOUT_SEC - 1);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_next;
  logic                 r_paused;
  logic                 w_paused_next;
  logic                 w_active;
  logic                 w_clr;
  logic                 w_sec_tick;
  logic [c_SECS_W-1:0]  w_secs;
  logic                 w_wash_end;
  logic                 w_rinse_end;
  logic                 w_spin_end;
  logic                 w_timeout;

  sec_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .SECS_W        (c_SECS_W)
  ) u_sec_timer (
    .clk190   (clk190),
    .rst      (rst),
    .clr      (w_clr),
    .en       (!r_paused),
    .sec_tick (w_sec_tick),
    .secs     (w_secs)
  );

  assign w_active    = is_active(r_state);
  assign w_clr       = (w_next != r_state);
  assign w_wash_end  = w_sec_tick && (w_secs == c_WASH_LAST);
  assign w_rinse_end = w_sec_tick && (w_secs == c_RINSE_LAST);
  assign w_spin_end  = w_sec_tick && (w_secs == c_SPIN_LAST);
  assign w_timeout   = w_sec_tick && (w_secs == c_TOUT_LAST);

  always_ff @(posedge clk190 or posedge rst) begin
    if (rst) begin
      r_state  <= c_ST_IDLE;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_paused <= w_paused_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_paused_next = r_paused;
    case (r_state)
      c_ST_IDLE:   if (start_p && door_closed) w_next = c_ST_FILL1;
      c_ST_FILL1:  if (!r_paused) begin
                     if (water_full)     w_next = c_ST_WASH;
                     else if (w_timeout) w_next = c_ST_FAULT;
                   end
      c_ST_WASH:   if (!r_paused && w_wash_end) w_next = c_ST_DRAIN1;
      c_ST_DRAIN1: if (!r_paused) begin
                     if (water_empty)    w_next = c_ST_FILL2;
                     else if (w_timeout) w_next = c_ST_FAULT;
                   end
      c_ST_FILL2:  if (!r_paused) begin
                     if (water_full)     w_next = c_ST_RINSE;
                     else if (w_timeout) w_next = c_ST_FAULT;
                   end
      c_ST_RINSE:  if (!r_paused && w_rinse_end) w_next = c_ST_DRAIN2;
      c_ST_DRAIN2: if (!r_paused) begin
                     if (water_empty)    w_next = c_ST_SPIN;
                     else if (w_timeout) w_next = c_ST_FAULT;
                   end
      c_ST_SPIN:   if (!r_paused && w_spin_end) w_next = c_ST_DONE;
      c_ST_DONE:   if (start_p || !door_closed) w_next = c_ST_IDLE;
      c_ST_FAULT:  w_next = c_ST_FAULT;
      default:     w_next = c_ST_FAULT;
    endcase

    // An open door overrides every other transition, paused or not.
    if (w_active && !door_closed) w_next = c_ST_FAULT;

    if (!is_active(w_next))         w_paused_next = 1'b0;
    else if (w_active && pause_p)   w_paused_next = !r_paused;
  end

  always_comb begin
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    motor_en    = 1'b0;
    motor_fast  = 1'b0;
    if (!r_paused) begin
      case (r_state)
        c_ST_FILL1, c_ST_FILL2:   fill_valve  = 1'b1;
        c_ST_DRAIN1, c_ST_DRAIN2: drain_valve = 1'b1;
        c_ST_WASH, c_ST_RINSE:    motor_en    = 1'b1;
        c_ST_SPIN: begin
          drain_valve = 1'b1;
          motor_en    = 1'b1;
          motor_fast  = 1'b1;
        end
        default: ;
      endcase
    end
    door_lock = w_active;
    done      = (r_state == c_ST_DONE);
    fault     = (r_state == c_ST_FAULT);
    paused    = r_paused;
    state_o   = r_state;
  end

endmodule

`default_nettype wire

// File: tb/tb_wash_cycle_ctrl.sv
// ============================================================================
// Module   : tb_wash_cycle_ctrl
// Purpose  : Directed self-checking bench for wash_cycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_cycle_ctrl;

  logic       clk190      = 1'b0;
  logic       rst         = 1'b1;
  logic       start_p     = 1'b0;
  logic       pause_p     = 1'b0;
  logic       door_closed = 1'b0;
  logic       water_full  = 1'b0;
  logic       water_empty = 1'b0;
  logic       fill_valve, drain_valve, motor_en, motor_fast;
  logic       door_lock, paused, done, fault;
  logic [3:0] state_o;

  wash_cycle_ctrl #(
    .TICKS_PER_SEC (4),
    .WASH_SEC      (2),
    .RINSE_SEC     (1),
    .SPIN_SEC      (2),
    .TIMEOUT_SEC   (3)
  ) dut (
    .clk190      (clk190),
    .rst         (rst),
    .start_p     (start_p),
    .pause_p     (pause_p),
    .door_closed (door_closed),
    .water_full  (water_full),
    .water_empty (water_empty),
    .fill_valve  (fill_valve),
    .drain_valve (drain_valve),
    .motor_en    (motor_en),
    .motor_fast  (motor_fast),
    .door_lock   (door_lock),
    .paused      (paused),
    .done        (done),
    .fault       (fault),
    .state_o     (state_o)
  );

  always #5 clk190 = ~clk190;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  // Output vector {fill, drain, motor_en, motor_fast, door_lock, paused, done, fault}
  function automatic logic [7:0] model_outs(input logic [3:0] s, input logic p);
    logic act;
    act = (s >= 4'd1) && (s <= 4'd7);
    return {!p && (s == 4'd1 || s == 4'd4),
            !p && (s == 4'd3 || s == 4'd6 || s == 4'd7),
            !p && (s == 4'd2 || s == 4'd5 || s == 4'd7),
            !p && (s == 4'd7),
            act,
            p,
            s == 4'd8,
            s == 4'd9};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk190);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [3:0] s, input logic p);
    sb_t e;
    e.tag = tag;
    e.exp = {s, model_outs(s, p)};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    sb_t         e;
    logic [11:0] obs;
    obs = {state_o, fill_valve, drain_valve, motor_en, motor_fast,
           door_lock, paused, done, fault};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed %h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Queue the expectation at drive time, compare once the DUT has had n edges.
  task automatic expect_after(input string tag, input logic [3:0] s, input logic p, input int n);
    push(tag, s, p);
    cyc(n);
    pop_check();
  endtask

  task automatic start_pulse();
    start_p = 1'b1;
    cyc(1);
    start_p = 1'b0;
  endtask

  task automatic fill_step();
    cyc(2);
    water_full = 1'b1;
    cyc(1);
    water_full = 1'b0;
  endtask

  task automatic drain_step();
    cyc(2);
    water_empty = 1'b1;
    cyc(1);
    water_empty = 1'b0;
  endtask

  initial begin
    cyc(2);
    expect_after("reset", 4'd0, 1'b0, 0);
    rst = 1'b0;
    cyc(1);

    // Start with the door open is ignored
    start_p = 1'b1;
    expect_after("start_door_open", 4'd0, 1'b0, 1);
    start_p = 1'b0;
    expect_after("door_open_hold", 4'd0, 1'b0, 2);

    // Happy path through the whole programme
    door_closed = 1'b1;
    start_p = 1'b1;
    expect_after("fill1", 4'd1, 1'b0, 1);
    start_p = 1'b0;
    cyc(2);
    water_full = 1'b1;
    expect_after("wash", 4'd2, 1'b0, 1);
    water_full = 1'b0;
    expect_after("wash_last", 4'd2, 1'b0, 7);
    expect_after("drain1", 4'd3, 1'b0, 1);
    cyc(2);
    water_empty = 1'b1;
    expect_after("fill2", 4'd4, 1'b0, 1);
    water_empty = 1'b0;
    cyc(2);
    water_full = 1'b1;
    expect_after("rinse", 4'd5, 1'b0, 1);
    water_full = 1'b0;
    expect_after("rinse_last", 4'd5, 1'b0, 3);
    expect_after("drain2", 4'd6, 1'b0, 1);
    cyc(2);
    water_empty = 1'b1;
    expect_after("spin", 4'd7, 1'b0, 1);
    water_empty = 1'b0;
    expect_after("spin_last", 4'd7, 1'b0, 7);
    expect_after("done", 4'd8, 1'b0, 1);
    start_p = 1'b1;
    expect_after("done_to_idle", 4'd0, 1'b0, 1);
    start_p = 1'b0;

    // Pause 3 cycles into WASH for 20 cycles
    start_pulse();
    fill_step();
    cyc(3);
    pause_p = 1'b1;
    expect_after("pause_on", 4'd2, 1'b1, 1);
    pause_p = 1'b0;
    expect_after("pause_hold", 4'd2, 1'b1, 18);
    cyc(1);
    pause_p = 1'b1;
    expect_after("pause_off", 4'd2, 1'b0, 1);
    pause_p = 1'b0;
    expect_after("wash_resume_last", 4'd2, 1'b0, 3);
    expect_after("drain1_after_pause", 4'd3, 1'b0, 1);
    pause_p = 1'b1;
    expect_after("pause_drain1", 4'd3, 1'b1, 1);
    pause_p = 1'b0;
    door_closed = 1'b0;
    expect_after("door_fault_paused", 4'd9, 1'b0, 1);

    // Fill timeout
    door_closed = 1'b1;
    rst = 1'b1;
    expect_after("rst_from_fault", 4'd0, 1'b0, 1);
    rst = 1'b0;
    start_pulse();
    expect_after("fill1_pre_timeout", 4'd1, 1'b0, 11);
    expect_after("fill_timeout", 4'd9, 1'b0, 1);
    start_p = 1'b1;
    expect_after("fault_ignores_start", 4'd9, 1'b0, 1);
    start_p = 1'b0;

    // Sensor and timeout on the same edge: sensor wins
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    start_pulse();
    cyc(11);
    water_full = 1'b1;
    expect_after("sensor_beats_timeout", 4'd2, 1'b0, 1);
    water_full = 1'b0;

    // Door opened during SPIN
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    start_pulse();
    fill_step();
    cyc(8);
    drain_step();
    fill_step();
    cyc(4);
    drain_step();
    expect_after("spin_reached", 4'd7, 1'b0, 0);
    cyc(2);
    door_closed = 1'b0;
    expect_after("spin_door_fault", 4'd9, 1'b0, 1);

    // Asynchronous reset mid-RINSE
    door_closed = 1'b1;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    start_pulse();
    fill_step();
    cyc(8);
    drain_step();
    fill_step();
    expect_after("rinse_before_rst", 4'd5, 1'b0, 1);
    #2;
    rst = 1'b1;
    #1;
    expect_after("async_rst", 4'd0, 1'b0, 0);
    cyc(1);
    rst = 1'b0;
    pause_p = 1'b1;
    expect_after("pause_in_idle_ignored", 4'd0, 1'b0, 1);
    start_p = 1'b1;
    expect_after("start_beats_pause", 4'd1, 1'b0, 1);
    start_p = 1'b0;
    pause_p = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
